// File: rtl/uart_rx.sv
// uart_rx: oversampling UART receiver (start, DATA_WIDTH data LSB first, optional parity, stop).
// Define UART_RX_MAJORITY_EN for 2-of-3 majority sampling; otherwise one mid-bit sample is used.
module uart_rx #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            Prescale,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  data_valid,
  output logic                  par_err,
  output logic                  stp_err
);

  localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BW-1:0] BC_LAST = BW'(DATA_WIDTH - 1);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] PARITY = 3'd3;
  localparam logic [2:0] STOP   = 3'd4;

  logic                  sync1;
  logic                  line;
  logic [2:0]            state;
  logic [5:0]            ec;
  logic [BW-1:0]         bc;
  logic [5:0]            p_lat;
  logic                  pe_lat;
  logic                  pt_lat;
  logic [DATA_WIDTH-1:0] sr;
  logic                  perr;
  logic [5:0]            half;
  logic                  last;
  logic                  dec;
  logic                  bit_v;

  assign half = {1'b0, p_lat[5:1]};
  assign last = (ec == p_lat - 6'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      sync1 <= 1'b1;
      line  <= 1'b1;
    end else begin
      sync1 <= RX_IN;
      line  <= sync1;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  logic smp0;
  logic smp1;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      smp0 <= 1'b0;
      smp1 <= 1'b0;
    end else begin
      if (ec == half - 6'd1) smp0 <= line;
      if (ec == half)        smp1 <= line;
    end
  end

  // third sample is the live line at the decision point
  assign dec   = (ec == half + 6'd1);
  assign bit_v = (smp0 & smp1) | (smp0 & line) | (smp1 & line);
`else
  assign dec   = (ec == half);
  assign bit_v = line;
`endif

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state      <= IDLE;
      ec         <= '0;
      bc         <= '0;
      p_lat      <= '0;
      pe_lat     <= 1'b0;
      pt_lat     <= 1'b0;
      sr         <= '0;
      perr       <= 1'b0;
      P_DATA     <= '0;
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
    end else begin
      data_valid <= 1'b0;
      par_err    <= 1'b0;
      stp_err    <= 1'b0;
      if (state != IDLE) ec <= last ? 6'd0 : ec + 6'd1;
      case (state)
        IDLE: begin
          ec <= '0;
          if (!line) begin
            state  <= START;
            bc     <= '0;
            p_lat  <= Prescale;
            pe_lat <= PAR_EN;
            pt_lat <= PAR_TYP;
            perr   <= 1'b0;
          end
        end
        START: begin
          if (dec && bit_v) begin
            state <= IDLE;
            ec    <= '0;
          end else if (last) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (dec) sr <= {bit_v, sr[DATA_WIDTH-1:1]};
          if (last) begin
            if (bc == BC_LAST) begin
              bc    <= '0;
              state <= pe_lat ? PARITY : STOP;
            end else begin
              bc <= bc + 1'b1;
            end
          end
        end
        PARITY: begin
          if (dec)  perr  <= bit_v ^ (^sr) ^ pt_lat;
          if (last) state <= STOP;
        end
        STOP: begin
          // leave at mid-bit so a back-to-back start edge is not missed
          if (dec) begin
            state   <= IDLE;
            ec      <= '0;
            par_err <= perr;
            stp_err <= ~bit_v;
            if (bit_v && !perr) begin
              P_DATA     <= sr;
              data_valid <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that pairs with the UART transmitter. It oversamples the serial line `RX_IN` at `Prescale` clocks per bit and recovers frames of 1 start bit, `DATA_WIDTH` data bits (LSB first), an optional parity bit and 1 stop bit. Each good frame is presented as a one-cycle `data_valid` pulse with `P_DATA`. The block sits on the receive path of the UART subsystem, on the same clock domain as the configuration registers that drive `PAR_EN`, `PAR_TYP` and `Prescale`.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame.
- `CLK` input 1: oversampling clock; all logic is on its rising edge.
- `RST` input 1: reset, asynchronous, active-low.
- `RX_IN` input 1: serial line, idle high, asynchronous to `CLK`.
- `PAR_EN` input 1: 1 means the frame carries a parity bit.
- `PAR_TYP` input 1: 0 selects even parity, 1 selects odd parity.
- `Prescale` input 6: clocks per bit. Legal values are even and in the range 8..32; 8, 16 and 32 are verified.
- `P_DATA` output DATA_WIDTH: last good received byte.
- `data_valid` output 1: one-cycle pulse, `P_DATA` is new.
- `par_err` output 1: one-cycle pulse, parity mismatch.
- `stp_err` output 1: one-cycle pulse, stop bit sampled low.

## Operation
- `RX_IN` passes through a 2-flop synchronizer (reset value 1). All references to "line" below mean the synchronized signal.
- Reset values: `P_DATA`=0, `data_valid`=0, `par_err`=0, `stp_err`=0, FSM in IDLE, all counters 0.
- Edge counter `ec` counts 0..P-1 within each bit, where P is `Prescale` latched on leaving IDLE. Bit counter `bc` counts the data bits.
- Sample points are `ec` = P/2-1, P/2 and P/2+1. The bit value is decided at `ec`=P/2+1.
- FSM states:
  - IDLE: on line=0, latch P, clear `ec`, go to START.
  - START: at the decision point, if the bit is 1 (glitch) return to IDLE with no outputs; if 0, at `ec`=P-1 go to DATA.
  - DATA: shift the decided bit into the shift register LSB-first. At `ec`=P-1 with `bc`=DATA_WIDTH-1, go to PARITY if `PAR_EN` else STOP.
  - PARITY: compare the decided bit with the XOR of the data bits XOR `PAR_TYP`, and record the mismatch. At `ec`=P-1 go to STOP.
  - STOP: at the decision point go to IDLE immediately, which allows a back-to-back start in the second half of the stop bit. In the same step:
    - load `P_DATA` and pulse `data_valid` only if there is no parity mismatch and the stop bit is 1;
    - pulse `par_err` on a recorded parity mismatch;
    - pulse `stp_err` if the stop bit is 0.
    - `par_err` and `stp_err` may pulse together.
- `P_DATA` holds its value until the next good frame; errored frames never modify it.
- `PAR_EN` and `PAR_TYP` are sampled on leaving IDLE. Changes mid-frame have no effect until the next frame. `Prescale` mid-frame changes are likewise ignored.
- Asynchronous reset mid-frame returns the block to IDLE with the reset output values. No partial frame is reported.

## Timing
- Output pulses are registered and occur one `CLK` after the stop-bit decision cycle.
- Latency from the falling edge of `RX_IN` (start bit) to `data_valid`: 2 (synchronizer) + 1 (detect) + P×(1+DATA_WIDTH+PAR_EN) + P/2+1 + 1 clocks.
- Each output pulse is exactly 1 cycle wide. There is no backpressure; the consumer must accept the pulse.
- The minimum gap between frames is 0 idle bits. A new start is detected on the first line=0 after the return to IDLE.

## Configuration
- `UART_RX_MAJORITY_EN`:
  - Defined: the bit value is the 2-of-3 majority of the three sample points, decided at `ec`=P/2+1.
  - Undefined: a single sample at `ec`=P/2 is used, decided at `ec`=P/2; the three-sample registers are not built.
  - All pulses and the latency formula shift 1 clock earlier when the macro is undefined.

## Test plan
- Prescale=8, PAR_EN=0: send 0xA5 → `data_valid` pulses once, `P_DATA`=0xA5, `par_err`=`stp_err`=0, latency matches the formula (= 81 clocks).
- Prescale=16, PAR_EN=1, PAR_TYP=0: send 0x3C with parity 0, then 0x3C with parity 1 → first frame gives `data_valid` with `P_DATA`=0x3C; second gives `par_err`=1 with `P_DATA` still 0x3C.
- Prescale=32, stop bit driven 0 on 0x55 → `stp_err` pulse, no `data_valid`, `P_DATA` unchanged.
- Start glitch: line low for 3 clocks at Prescale=16 → no pulses, FSM back in IDLE. Then 0x81 sent → `P_DATA`=0x81.
- Back-to-back: 0x01, 0xFE and 0x7E with zero idle bits at Prescale=8, PAR_EN=1, PAR_TYP=1 → three `data_valid` pulses with the correct bytes.
- `RST` low mid-DATA → all outputs 0 immediately. After release, a 0x42 frame is received correctly. With `UART_RX_MAJORITY_EN`, a single-clock inverted spike at `ec`=P/2 does not corrupt the bit.
